lot_ctrl: RTL and testbench

Admission sequencer for the parking lot counter. Takes the one-cycle `inc`/`dec` car events from the detector and decides whether to admit each car against a fixed capacity. It issues single-cycle increment/decrement commands to the BCD counter, times the entry and exit gates, and flags full/deny/error conditions for the display path. It sits between the detector and the BCD counter, clocked by `clk`, reset by the synchronized `reset`.

---
 rtl/lot_ctrl_if.sv | 32 +++
 rtl/lot_ctrl.sv | 153 +++++++++++++++
 tb/tb_lot_ctrl.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/lot_ctrl_if.sv
// lot_ctrl_if: connection bundle between the parking-lot admission sequencer
// and its neighbours (detector events in, counter commands / gate and status
// flags out).
//   inc, dec            : one-cycle car events from the detector
//   cnt_inc, cnt_dec    : one-cycle commands to the BCD counter
//   gate_in, gate_out   : gate open levels
//   occupancy           : binary car count
//   full, deny, err     : status flags for the display path
// Modports: master drives the events and observes the rest (detector or bench
// side); slave is the sequencer itself.
interface lot_ctrl_if;
  logic       inc;
  logic       dec;
  logic       cnt_inc;
  logic       cnt_dec;
  logic       gate_in;
  logic       gate_out;
  logic [6:0] occupancy;
  logic       full;
  logic       deny;
  logic       err;

  modport master (
    output inc, dec,
    input  cnt_inc, cnt_dec, gate_in, gate_out, occupancy, full, deny, err
  );

  modport slave (
    input  inc, dec,
    output cnt_inc, cnt_dec, gate_in, gate_out, occupancy, full, deny, err
  );
endinterface

// File: rtl/lot_ctrl.sv
// lot_ctrl: parking-lot admission sequencer.
// Latches detector entry/exit events into 1-deep pending flags, admits cars
// against CAPACITY, issues single-cycle commands to the BCD counter, holds the
// matching gate open for GATE_CYCLES cycles, and flags full/deny/err.
// Ports:
//   clk   : system clock
//   reset : synchronous, active-high reset
//   bus   : lot_ctrl_if.slave (events in; commands, gates, occupancy, flags out)
// Parameters:
//   CAPACITY    : maximum occupancy, 1..99
//   GATE_CYCLES : cycles a gate stays open per car, >= 2
// All outputs are registered.
module lot_ctrl #(
  parameter int CAPACITY    = 20,
  parameter int GATE_CYCLES = 50_000_000
) (
  input  logic        clk,
  input  logic        reset,
  lot_ctrl_if.slave   bus
);

  localparam int               TMR_W    = (GATE_CYCLES > 2) ? $clog2(GATE_CYCLES) : 1;
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(GATE_CYCLES - 1);
  localparam logic [6:0]       CAP      = 7'(CAPACITY);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    GATE_IN  = 2'd1,
    GATE_OUT = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [TMR_W-1:0] tmr_q, tmr_d;
  logic             pend_in_q, pend_in_d;
  logic             pend_out_q, pend_out_d;
  logic [6:0]       occ_q, occ_d;
  logic             full_q, full_d;
  logic             cnt_inc_q, cnt_inc_d;
  logic             cnt_dec_q, cnt_dec_d;
  logic             gate_in_q, gate_in_d;
  logic             gate_out_q, gate_out_d;
  logic             deny_q, deny_d;
  logic             err_q, err_d;

  // Exit/entry requests seen in IDLE: anything already pending plus this
  // cycle's pulse, so an event arriving in IDLE is served with latency 1.
  logic want_out, want_in;
  assign want_out = pend_out_q | bus.dec;
  assign want_in  = pend_in_q  | bus.inc;

  // NOTE: every signal written here gets a default first, so no path through
  // the case can leave one unassigned and infer a latch.
  always_comb begin
    state_d    = state_q;
    tmr_d      = tmr_q;
    pend_in_d  = pend_in_q  | bus.inc;
    pend_out_d = pend_out_q | bus.dec;
    occ_d      = occ_q;
    cnt_inc_d  = 1'b0;
    cnt_dec_d  = 1'b0;
    deny_d     = 1'b0;
    // An event arriving while its flag is still set has nowhere to go.
    err_d      = (bus.inc & pend_in_q) | (bus.dec & pend_out_q);

    unique case (state_q)
      IDLE: begin
        tmr_d = '0;
        if (want_out) begin
          // Exit takes priority; a simultaneous entry stays latched in pend_in.
          pend_out_d = 1'b0;
          if (occ_q != 7'd0) begin
            state_d   = GATE_OUT;
            cnt_dec_d = 1'b1;
            occ_d     = occ_q - 7'd1;
          end else begin
            err_d = 1'b1;
          end
        end else if (want_in) begin
          pend_in_d = 1'b0;
          if (occ_q < CAP) begin
            state_d   = GATE_IN;
            cnt_inc_d = 1'b1;
            occ_d     = occ_q + 7'd1;
          end else begin
            deny_d = 1'b1;
          end
        end
      end

      GATE_IN, GATE_OUT: begin
        if (tmr_q == TMR_LAST) begin
          state_d = IDLE;
          tmr_d   = '0;
        end else begin
          tmr_d = tmr_q + 1'b1;
        end
      end

      default: begin
        state_d = IDLE;
        tmr_d   = '0;
      end
    endcase

    // Gate levels and full follow the next state so they change on the same
    // edge as the state and occupancy they describe.
    gate_in_d  = (state_d == GATE_IN);
    gate_out_d = (state_d == GATE_OUT);
    full_d     = (occ_d == CAP);
  end

  // NOTE: state is updated with non-blocking assignments so every register
  // samples the pre-edge values computed above, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      tmr_q      <= '0;
      pend_in_q  <= 1'b0;
      pend_out_q <= 1'b0;
      occ_q      <= '0;
      full_q     <= 1'b0;
      cnt_inc_q  <= 1'b0;
      cnt_dec_q  <= 1'b0;
      gate_in_q  <= 1'b0;
      gate_out_q <= 1'b0;
      deny_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      tmr_q      <= tmr_d;
      pend_in_q  <= pend_in_d;
      pend_out_q <= pend_out_d;
      occ_q      <= occ_d;
      full_q     <= full_d;
      cnt_inc_q  <= cnt_inc_d;
      cnt_dec_q  <= cnt_dec_d;
      gate_in_q  <= gate_in_d;
      gate_out_q <= gate_out_d;
      deny_q     <= deny_d;
      err_q      <= err_d;
    end
  end

  assign bus.cnt_inc   = cnt_inc_q;
  assign bus.cnt_dec   = cnt_dec_q;
  assign bus.gate_in   = gate_in_q;
  assign bus.gate_out  = gate_out_q;
  assign bus.occupancy = occ_q;
  assign bus.full      = full_q;
  assign bus.deny      = deny_q;
  assign bus.err       = err_q;

endmodule

// File: tb/tb_lot_ctrl.sv
// tb_lot_ctrl: directed table-driven bench for lot_ctrl with CAPACITY=2,
// GATE_CYCLES=4. Each table row holds the inputs driven for one cycle and the
// outputs expected just after the following rising edge.
module tb_lot_ctrl;

  logic clk;
  logic reset;

  lot_ctrl_if bus ();

  lot_ctrl #(
    .CAPACITY    (2),
    .GATE_CYCLES (4)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic       r, i, d;
    logic       ci, cd, gi, go;
    logic [6:0] occ;
    logic       f, dn, e;
  } vec_t;

  int n_vec = 0;
  int n_err = 0;
  vec_t vecs[$];

  function automatic vec_t mk(string name, logic r, logic i, logic d,
                              logic ci, logic cd, logic gi, logic go,
                              int occ, logic f, logic dn, logic e);
    vec_t v;
    v.name = name; v.r = r; v.i = i; v.d = d;
    v.ci = ci; v.cd = cd; v.gi = gi; v.go = go;
    v.occ = 7'(occ); v.f = f; v.dn = dn; v.e = e;
    return v;
  endfunction

  task automatic check(string nm, logic [31:0] got, logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
    end
  endtask

  // Output word layout: {cnt_inc, cnt_dec, gate_in, gate_out, occupancy, full, deny, err}
  function automatic logic [31:0] pack_out();
    return 32'({bus.cnt_inc, bus.cnt_dec, bus.gate_in, bus.gate_out,
                bus.occupancy, bus.full, bus.deny, bus.err});
  endfunction

  initial begin
    int gate_cnt;
    int ci_cnt;

    reset   = 1'b1;
    bus.inc = 1'b0;
    bus.dec = 1'b0;

    //                 name          r  i  d   ci cd gi go occ f dn e
    vecs.push_back(mk("reset0",     1, 0, 0,  0, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk("reset1",     1, 0, 0,  0, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk("idle",       0, 0, 0,  0, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk("inc1",       0, 1, 0,  1, 0, 1, 0, 1, 0, 0, 0));
    vecs.push_back(mk("gin1_t1",    0, 0, 0,  0, 0, 1, 0, 1, 0, 0, 0));
    vecs.push_back(mk("gin1_t2",    0, 0, 0,  0, 0, 1, 0, 1, 0, 0, 0));
    vecs.push_back(mk("gin1_t3",    0, 0, 0,  0, 0, 1, 0, 1, 0, 0, 0));
    vecs.push_back(mk("gin1_close", 0, 0, 0,  0, 0, 0, 0, 1, 0, 0, 0));
    vecs.push_back(mk("idle_occ1",  0, 0, 0,  0, 0, 0, 0, 1, 0, 0, 0));
    vecs.push_back(mk("inc2_full",  0, 1, 0,  1, 0, 1, 0, 2, 1, 0, 0));
    vecs.push_back(mk("gin2_t1",    0, 0, 0,  0, 0, 1, 0, 2, 1, 0, 0));
    vecs.push_back(mk("gin2_t2",    0, 0, 0,  0, 0, 1, 0, 2, 1, 0, 0));
    vecs.push_back(mk("gin2_t3",    0, 0, 0,  0, 0, 1, 0, 2, 1, 0, 0));
    vecs.push_back(mk("gin2_close", 0, 0, 0,  0, 0, 0, 0, 2, 1, 0, 0));
    vecs.push_back(mk("inc3_deny",  0, 1, 0,  0, 0, 0, 0, 2, 1, 1, 0));
    vecs.push_back(mk("deny_off",   0, 0, 0,  0, 0, 0, 0, 2, 1, 0, 0));
    vecs.push_back(mk("dec_to1",    0, 0, 1,  0, 1, 0, 1, 1, 0, 0, 0));
    vecs.push_back(mk("gout1_t1",   0, 0, 0,  0, 0, 0, 1, 1, 0, 0, 0));
    vecs.push_back(mk("gout1_t2",   0, 0, 0,  0, 0, 0, 1, 1, 0, 0, 0));
    vecs.push_back(mk("gout1_t3",   0, 0, 0,  0, 0, 0, 1, 1, 0, 0, 0));
    vecs.push_back(mk("gout1_close",0, 0, 0,  0, 0, 0, 0, 1, 0, 0, 0));
    vecs.push_back(mk("both_exit",  0, 1, 1,  0, 1, 0, 1, 0, 0, 0, 0));
    vecs.push_back(mk("both_t1",    0, 0, 0,  0, 0, 0, 1, 0, 0, 0, 0));
    vecs.push_back(mk("both_t2",    0, 0, 0,  0, 0, 0, 1, 0, 0, 0, 0));
    vecs.push_back(mk("both_t3",    0, 0, 0,  0, 0, 0, 1, 0, 0, 0, 0));
    vecs.push_back(mk("both_idle",  0, 0, 0,  0, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk("both_entry", 0, 0, 0,  1, 0, 1, 0, 1, 0, 0, 0));
    vecs.push_back(mk("bent_t1",    0, 0, 0,  0, 0, 1, 0, 1, 0, 0, 0));
    vecs.push_back(mk("bent_t2",    0, 0, 0,  0, 0, 1, 0, 1, 0, 0, 0));
    vecs.push_back(mk("bent_t3",    0, 0, 0,  0, 0, 1, 0, 1, 0, 0, 0));
    vecs.push_back(mk("bent_close", 0, 0, 0,  0, 0, 0, 0, 1, 0, 0, 0));
    vecs.push_back(mk("dec_to0",    0, 0, 1,  0, 1, 0, 1, 0, 0, 0, 0));
    vecs.push_back(mk("gout0_t1",   0, 0, 0,  0, 0, 0, 1, 0, 0, 0, 0));
    vecs.push_back(mk("gout0_t2",   0, 0, 0,  0, 0, 0, 1, 0, 0, 0, 0));
    vecs.push_back(mk("gout0_t3",   0, 0, 0,  0, 0, 0, 1, 0, 0, 0, 0));
    vecs.push_back(mk("gout0_close",0, 0, 0,  0, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk("dec_at_zero",0, 0, 1,  0, 0, 0, 0, 0, 0, 0, 1));
    vecs.push_back(mk("err_off",    0, 0, 0,  0, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk("pin_inc",    0, 1, 0,  1, 0, 1, 0, 1, 0, 0, 0));
    vecs.push_back(mk("pin_latch",  0, 1, 0,  0, 0, 1, 0, 1, 0, 0, 0));
    vecs.push_back(mk("pin_drop",   0, 1, 0,  0, 0, 1, 0, 1, 0, 0, 1));
    vecs.push_back(mk("pin_t3",     0, 0, 0,  0, 0, 1, 0, 1, 0, 0, 0));
    vecs.push_back(mk("pin_close",  0, 0, 0,  0, 0, 0, 0, 1, 0, 0, 0));
    vecs.push_back(mk("pin_served", 0, 0, 0,  1, 0, 1, 0, 2, 1, 0, 0));
    vecs.push_back(mk("pins_t1",    0, 0, 0,  0, 0, 1, 0, 2, 1, 0, 0));
    vecs.push_back(mk("pins_t2",    0, 0, 0,  0, 0, 1, 0, 2, 1, 0, 0));
    vecs.push_back(mk("pins_t3",    0, 0, 0,  0, 0, 1, 0, 2, 1, 0, 0));
    vecs.push_back(mk("pins_close", 0, 0, 0,  0, 0, 0, 0, 2, 1, 0, 0));
    vecs.push_back(mk("rs_dec",     0, 0, 1,  0, 1, 0, 1, 1, 0, 0, 0));
    vecs.push_back(mk("rs_gout_t1", 0, 0, 0,  0, 0, 0, 1, 1, 0, 0, 0));
    vecs.push_back(mk("rs_gout_t2", 0, 0, 0,  0, 0, 0, 1, 1, 0, 0, 0));
    vecs.push_back(mk("rs_gout_t3", 0, 0, 0,  0, 0, 0, 1, 1, 0, 0, 0));
    vecs.push_back(mk("rs_idle",    0, 0, 0,  0, 0, 0, 0, 1, 0, 0, 0));
    vecs.push_back(mk("rs_inc",     0, 1, 0,  1, 0, 1, 0, 2, 1, 0, 0));
    vecs.push_back(mk("rs_pend_dec",0, 0, 1,  0, 0, 1, 0, 2, 1, 0, 0));
    vecs.push_back(mk("rs_reset",   1, 0, 0,  0, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk("rs_after1",  0, 0, 0,  0, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk("rs_after2",  0, 0, 0,  0, 0, 0, 0, 0, 0, 0, 0));

    foreach (vecs[k]) begin
      reset   = vecs[k].r;
      bus.inc = vecs[k].i;
      bus.dec = vecs[k].d;
      @(posedge clk);
      #1;
      check(vecs[k].name, pack_out(),
            32'({vecs[k].ci, vecs[k].cd, vecs[k].gi, vecs[k].go,
                 vecs[k].occ, vecs[k].f, vecs[k].dn, vecs[k].e}));
      check({vecs[k].name, "_excl"}, 32'(bus.cnt_inc & bus.cnt_dec), 32'd0);
    end

    // Gate width measured independently of the table: one entry from empty,
    // count gate_in cycles and cnt_inc pulses under a bounded wait.
    reset    = 1'b0;
    bus.dec  = 1'b0;
    bus.inc  = 1'b1;
    gate_cnt = 0;
    ci_cnt   = 0;
    @(posedge clk);
    #1;
    bus.inc = 1'b0;
    for (int k = 0; k < 20; k++) begin
      if (bus.gate_in) gate_cnt++;
      if (bus.cnt_inc) ci_cnt++;
      if (!bus.gate_in) break;
      @(posedge clk);
      #1;
    end
    check("gate_width", 32'(gate_cnt), 32'd4);
    check("cnt_inc_pulses", 32'(ci_cnt), 32'd1);
    check("occ_after_gate", 32'(bus.occupancy), 32'd1);
    check("gate_closed", 32'(bus.gate_in), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
